pic_ack_sequencer: RTL

//  Sequences the 8259 interrupt-acknowledge handshake between the CPU INTA_n strobes and the control logic.

---
 rtl/pic_pkg.sv | 30 +++
 rtl/pic_ack_sequencer_if.sv | 32 +++
 rtl/pic_inta_sync.sv | 30 +++
 rtl/pic_ack_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259 interrupt-acknowledge sequencer.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK1  = 3'd1,
    WAIT2 = 3'd2,
    ACK2  = 3'd3,
    WAIT3 = 3'd4,
    ACK3  = 3'd5
  } ack_state_t;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;
  localparam logic [7:0] IR7_ONEHOT  = 8'h80;

  // An empty request maps to IR7 so spurious acknowledges still yield a vector.
  function automatic logic [2:0] bit2num(input logic [7:0] onehot);
    logic [2:0] num;
    num = 3'b111;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) num = i[2:0];
    end
    return num;
  endfunction

  function automatic logic [7:0] num2bit(input logic [2:0] num);
    return 8'b1 << num;
  endfunction

endpackage

// File: rtl/pic_ack_sequencer_if.sv
// Acknowledge-path signals between the bus/control logic (master) and the sequencer (slave).
interface pic_ack_sequencer_if;
  logic       inta_n;
  logic       write_initial_command_word_1;
  logic [7:0] interrupt_pending;
  logic [4:0] vector_base;
  logic       auto_eoi_config;
  logic       mcs80_mode;
  logic [7:0] call_address_base;
  logic       interrupt_to_cpu;
  logic       freeze;
  logic       latch_in_service;
  logic [7:0] acknowledge_interrupt;
  logic       end_of_acknowledge_sequence;
  logic       auto_eoi_clear;
  logic       data_out_en;
  logic [7:0] data_out;

  modport master (
    output inta_n, write_initial_command_word_1, interrupt_pending, vector_base,
           auto_eoi_config, mcs80_mode, call_address_base,
    input  interrupt_to_cpu, freeze, latch_in_service, acknowledge_interrupt,
           end_of_acknowledge_sequence, auto_eoi_clear, data_out_en, data_out
  );

  modport slave (
    input  inta_n, write_initial_command_word_1, interrupt_pending, vector_base,
           auto_eoi_config, mcs80_mode, call_address_base,
    output interrupt_to_cpu, freeze, latch_in_service, acknowledge_interrupt,
           end_of_acknowledge_sequence, auto_eoi_clear, data_out_en, data_out
  );
endinterface

// File: rtl/pic_inta_sync.sv
// Synchronises the async INTA_n pin and emits one-cycle fall/rise events.
// Events are combinational off the last two flops: valid SYNC_STAGES+1 cycles after the pin edge.
module pic_inta_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Clearing to "low" means a pin still held low across reset never looks like a fresh fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall = prev_q & ~sync_q[SYNC_STAGES-1];
  assign rise = ~prev_q & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pic_ack_sequencer.sv
// 8259 INTA handshake sequencer: INT, freeze, ISR latch, vector bytes, end-of-ack/AEOI pulses.
// Control outputs are registered; data bus is decoded from state. PIC_MCS80_MODE_EN adds the 3-pulse MCS-80 mode.
module pic_ack_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               reset,
  pic_ack_sequencer_if.slave bus
);

  ack_state_t state_q, state_d;
  logic [7:0] ack_q, ack_d;
  logic       spurious_q, spurious_d;
  logic       mcs_q, mcs_d;
  logic       int_q, int_d;
  logic       latch_q, latch_d;
  logic       end_q, end_d;
  logic       aeoi_q, aeoi_d;
  logic       fall, rise, mcs_sel, finish;
  logic [2:0] ack_num;

  pic_inta_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .inta_n(bus.inta_n),
    .fall  (fall),
    .rise  (rise)
  );

`ifdef PIC_MCS80_MODE_EN
  assign mcs_sel = bus.mcs80_mode;
`else
  logic unused_mcs_cfg;
  assign mcs_sel        = 1'b0;
  assign unused_mcs_cfg = ^{bus.mcs80_mode, bus.call_address_base};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      spurious_q <= 1'b0;
      mcs_q      <= 1'b0;
      int_q      <= 1'b0;
      latch_q    <= 1'b0;
      end_q      <= 1'b0;
      aeoi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      spurious_q <= spurious_d;
      mcs_q      <= mcs_d;
      int_q      <= int_d;
      latch_q    <= latch_d;
      end_q      <= end_d;
      aeoi_q     <= aeoi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    spurious_d = spurious_q;
    mcs_d      = mcs_q;
    int_d      = (state_q == IDLE) && (|bus.interrupt_pending);
    latch_d    = 1'b0;
    finish     = 1'b0;

    if (bus.write_initial_command_word_1) begin
      state_d    = IDLE;
      ack_d      = '0;
      spurious_d = 1'b0;
      mcs_d      = 1'b0;
      int_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (fall) begin
          // Request is sampled only here; later resolver changes are ignored until the end.
          state_d = ACK1;
          int_d   = 1'b0;
          mcs_d   = mcs_sel;
          if (|bus.interrupt_pending) begin
            ack_d      = bus.interrupt_pending;
            spurious_d = 1'b0;
            latch_d    = 1'b1;
          end else begin
            ack_d      = IR7_ONEHOT;
            spurious_d = 1'b1;
          end
        end
        ACK1:  if (rise) state_d = WAIT2;
        WAIT2: if (fall) state_d = ACK2;
        ACK2:  if (rise) begin
          if (mcs_q) state_d = WAIT3;
          else       finish  = 1'b1;
        end
        WAIT3: if (fall) state_d = ACK3;
        ACK3:  if (rise) finish = 1'b1;
        default: state_d = IDLE;
      endcase
      if (finish) state_d = IDLE;
    end

    end_d  = finish;
    aeoi_d = finish && bus.auto_eoi_config && !spurious_q;
  end

  assign ack_num = bit2num(ack_q);

  always_comb begin
    bus.data_out_en = 1'b0;
    bus.data_out    = '0;
    case (state_q)
`ifdef PIC_MCS80_MODE_EN
      ACK1: if (mcs_q) begin
        bus.data_out_en = 1'b1;
        bus.data_out    = CALL_OPCODE;
      end
      ACK2: begin
        bus.data_out_en = 1'b1;
        bus.data_out    = mcs_q ? {bus.call_address_base[7:5], ack_num, 2'b00}
                                : {bus.vector_base, ack_num};
      end
      ACK3: begin
        bus.data_out_en = 1'b1;
        bus.data_out    = {bus.vector_base, 3'b000};
      end
`else
      ACK2: begin
        bus.data_out_en = 1'b1;
        bus.data_out    = {bus.vector_base, ack_num};
      end
`endif
      default: ;
    endcase
  end

  assign bus.interrupt_to_cpu            = int_q;
  assign bus.freeze                      = (state_q != IDLE);
  assign bus.latch_in_service            = latch_q;
  assign bus.acknowledge_interrupt       = ack_q;
  assign bus.end_of_acknowledge_sequence = end_q;
  assign bus.auto_eoi_clear              = aeoi_q;

endmodule
